// File: rtl/pll_reconfig_ctrl_if.sv
// Configuration request channel between system control (master) and the
// PLL reconfiguration controller (slave).
interface pll_reconfig_ctrl_if;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [9:0] cfg_idiv;
    logic [9:0] cfg_fdiv;
    logic [9:0] cfg_odiv0;
    logic [9:0] cfg_duty0;

    modport master (
        output cfg_valid,
        output cfg_idiv,
        output cfg_fdiv,
        output cfg_odiv0,
        output cfg_duty0,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_idiv,
        input  cfg_fdiv,
        input  cfg_odiv0,
        input  cfg_duty0,
        output cfg_ready
    );
endinterface

// File: rtl/pll_reconfig_ctrl.sv
// PLL dynamic-configuration and reset sequencer: applies divider settings,
// pulses pll_rst, qualifies a synchronized lock with timeout/retry, reports health.
module pll_reconfig_ctrl #(
    parameter int RST_CYCLES   = 16,
    parameter int LOCK_TIMEOUT = 50000,
    parameter int LOCK_STABLE  = 64,
    parameter int RETRY_MAX    = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    pll_reconfig_ctrl_if.slave   cfg,
    input  logic                 pll_lock,
    output logic                 pll_rst,
    output logic [9:0]           dyn_idiv,
    output logic [9:0]           dyn_fdiv,
    output logic [9:0]           dyn_odiv0,
    output logic [9:0]           dyn_duty0,
    output logic                 clk_ok,
    output logic                 done,
    output logic                 err,
    output logic [7:0]           lock_loss_cnt
);
    localparam int RST_W = (RST_CYCLES > 1)   ? $clog2(RST_CYCLES)   : 1;
    localparam int TMR_W = $clog2(LOCK_TIMEOUT);
    localparam int STB_W = (LOCK_STABLE > 2)  ? $clog2(LOCK_STABLE)  : 1;
    localparam int RTY_W = $clog2(RETRY_MAX + 1);

    localparam logic [RST_W-1:0] RST_LAST  = RST_W'(RST_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(LOCK_TIMEOUT - 1);
    // The WAIT_LOCK cycle that first sees lock_s counts as one qualified cycle.
    localparam logic [STB_W-1:0] STB_LAST  = STB_W'((LOCK_STABLE >= 2) ? LOCK_STABLE - 2 : 0);
    localparam logic [RTY_W-1:0] RETRY_LIM = RTY_W'(RETRY_MAX);

    typedef enum logic [2:0] {
        S_PLL_RST,
        S_WAIT_LOCK,
        S_STABLE,
        S_RUN,
        S_FAIL
    } state_t;

    state_t             state, state_nx;
    logic [RST_W-1:0]   rst_cnt, rst_cnt_nx;
    logic [TMR_W-1:0]   timer, timer_nx;
    logic [STB_W-1:0]   stb_cnt, stb_cnt_nx;
    logic [RTY_W-1:0]   retry, retry_nx, retry_inc;
    logic [7:0]         loss_nx;
    logic               lock_p0, lock_p1, lock_s;
    logic               ready, accept, cfg_zero, load, reject;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Synchronizer stages for the asynchronous lock input
    always_ff @(posedge clk) begin
        if (rst) begin
            lock_p0 <= 1'b0;
            lock_p1 <= 1'b0;
        end else begin
            lock_p0 <= pll_lock;
            lock_p1 <= lock_p0;
        end
    end
    assign lock_s = lock_p1;

    assign ready         = (state == S_RUN) || (state == S_FAIL);
    assign cfg.cfg_ready = ready;
    assign pll_rst       = (state == S_PLL_RST);
    assign clk_ok        = (state == S_RUN);

    assign accept    = cfg.cfg_valid && ready;
    assign cfg_zero  = (cfg.cfg_idiv == 10'd0) || (cfg.cfg_fdiv == 10'd0) ||
                       (cfg.cfg_odiv0 == 10'd0) || (cfg.cfg_duty0 == 10'd0);
    assign retry_inc = retry + RTY_W'(1);

    always_comb begin
        state_nx   = state;
        rst_cnt_nx = rst_cnt;
        timer_nx   = timer;
        stb_cnt_nx = stb_cnt;
        retry_nx   = retry;
        loss_nx    = lock_loss_cnt;
        load       = 1'b0;
        reject     = 1'b0;

        case (state)
            S_PLL_RST: begin
                if (rst_cnt == RST_LAST) begin
                    state_nx = S_WAIT_LOCK;
                    timer_nx = '0;
                end else begin
                    rst_cnt_nx = rst_cnt + RST_W'(1);
                end
            end
            S_WAIT_LOCK: begin
                if (lock_s) begin
                    if (LOCK_STABLE == 1) begin
                        state_nx = S_RUN;
                        retry_nx = '0;
                    end else begin
                        state_nx   = S_STABLE;
                        stb_cnt_nx = '0;
                    end
                end else if (timer == TMR_LAST) begin
                    retry_nx = retry_inc;
                    if (retry_inc < RETRY_LIM) begin
                        state_nx   = S_PLL_RST;
                        rst_cnt_nx = '0;
                    end else begin
                        state_nx = S_FAIL;
                    end
                end else begin
                    timer_nx = timer + TMR_W'(1);
                end
            end
            S_STABLE: begin
                // Timer is kept on a glitch so the attempt stays bounded.
                if (!lock_s) begin
                    state_nx = S_WAIT_LOCK;
                end else if (stb_cnt == STB_LAST) begin
                    state_nx = S_RUN;
                    retry_nx = '0;
                end else begin
                    stb_cnt_nx = stb_cnt + STB_W'(1);
                end
            end
            S_RUN: begin
                if (!lock_s) begin
                    state_nx = S_WAIT_LOCK;
                    timer_nx = '0;
                    loss_nx  = sat_inc8(lock_loss_cnt);
                end
            end
            S_FAIL: begin
                state_nx = S_FAIL;
            end
            default: begin
                state_nx   = S_PLL_RST;
                rst_cnt_nx = '0;
            end
        endcase

        if (accept) begin
            if (cfg_zero) begin
                reject = 1'b1;
            end else begin
                load       = 1'b1;
                state_nx   = S_PLL_RST;
                rst_cnt_nx = '0;
                retry_nx   = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_PLL_RST;
            rst_cnt       <= '0;
            timer         <= '0;
            stb_cnt       <= '0;
            retry         <= '0;
            lock_loss_cnt <= 8'd0;
            done          <= 1'b0;
            err           <= 1'b0;
        end else begin
            state         <= state_nx;
            rst_cnt       <= rst_cnt_nx;
            timer         <= timer_nx;
            stb_cnt       <= stb_cnt_nx;
            retry         <= retry_nx;
            lock_loss_cnt <= loss_nx;
            done          <= (state_nx == S_RUN) && (state != S_RUN);
            err           <= reject || ((state_nx == S_FAIL) && (state != S_FAIL));
        end
    end

    // Settings register: power-up defaults, otherwise changes only on accept
    always_ff @(posedge clk) begin
        if (rst) begin
            dyn_idiv  <= 10'd2;
            dyn_fdiv  <= 10'd32;
            dyn_odiv0 <= 10'd100;
            dyn_duty0 <= 10'd100;
        end else if (load) begin
            dyn_idiv  <= cfg.cfg_idiv;
            dyn_fdiv  <= cfg.cfg_fdiv;
            dyn_odiv0 <= cfg.cfg_odiv0;
            dyn_duty0 <= cfg.cfg_duty0;
        end
    end
endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// Directed bench for pll_reconfig_ctrl with a done-timing scoreboard and
// a pll_rst pulse-width monitor.
module tb_pll_reconfig_ctrl;
    localparam int RST_CYCLES   = 16;
    localparam int LOCK_TIMEOUT = 100;
    localparam int LOCK_STABLE  = 64;
    localparam int RETRY_MAX    = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pll_lock = 1'b0;
    logic       pll_rst, clk_ok, done, err;
    logic [9:0] dyn_idiv, dyn_fdiv, dyn_odiv0, dyn_duty0;
    logic [7:0] lock_loss_cnt;

    pll_reconfig_ctrl_if cfg_bus ();

    pll_reconfig_ctrl #(
        .RST_CYCLES   (RST_CYCLES),
        .LOCK_TIMEOUT (LOCK_TIMEOUT),
        .LOCK_STABLE  (LOCK_STABLE),
        .RETRY_MAX    (RETRY_MAX)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cfg           (cfg_bus),
        .pll_lock      (pll_lock),
        .pll_rst       (pll_rst),
        .dyn_idiv      (dyn_idiv),
        .dyn_fdiv      (dyn_fdiv),
        .dyn_odiv0     (dyn_odiv0),
        .dyn_duty0     (dyn_duty0),
        .clk_ok        (clk_ok),
        .done          (done),
        .err           (err),
        .lock_loss_cnt (lock_loss_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int exp_done_q[$];
    int pushes = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int rst_pulses = 0;
    int rst_len = 0;
    logic rst_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // done is expected LOCK_STABLE+2 cycles after pll_lock rises in WAIT_LOCK
    task automatic raise_lock_expect_done();
        pll_lock = 1'b1;
        exp_done_q.push_back(cyc + LOCK_STABLE + 2);
        pushes++;
    endtask

    task automatic wait_clk_ok(input string tag);
        for (int i = 0; i < 200 && !clk_ok; i++) @(negedge clk);
        chk(tag, clk_ok, 1);
    endtask

    task automatic wait_pll_rst_low(input string tag);
        for (int i = 0; i < 60 && pll_rst; i++) @(negedge clk);
        chk(tag, pll_rst, 0);
    endtask

    task automatic send_cfg(input logic [9:0] i, input logic [9:0] f,
                            input logic [9:0] o, input logic [9:0] d, input logic drop_lock);
        cfg_bus.cfg_idiv  = i;
        cfg_bus.cfg_fdiv  = f;
        cfg_bus.cfg_odiv0 = o;
        cfg_bus.cfg_duty0 = d;
        cfg_bus.cfg_valid = 1'b1;
        if (drop_lock) pll_lock = 1'b0;
        for (int k = 0; k < 1000 && !cfg_bus.cfg_ready; k++) @(negedge clk);
        chk("cfg_ready_seen", cfg_bus.cfg_ready, 1);
        @(negedge clk);
        cfg_bus.cfg_valid = 1'b0;
    endtask

    task automatic chk_dyn(input string tag, input int i, input int f, input int o, input int d);
        chk({tag, "_idiv"}, dyn_idiv, i);
        chk({tag, "_fdiv"}, dyn_fdiv, f);
        chk({tag, "_odiv0"}, dyn_odiv0, o);
        chk({tag, "_duty0"}, dyn_duty0, d);
    endtask

    // Monitor: sampled 1 time unit after each rising edge
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (pll_rst) begin
                rst_len = (rst || !rst_prev) ? 1 : rst_len + 1;
                if (!rst_prev) rst_pulses++;
            end else if (rst_prev) begin
                chk("pll_rst_width", rst_len, RST_CYCLES);
            end
            rst_prev = pll_rst;
            if (done || err) chk("done_err_exclusive", done && err, 0);
            if (err) err_cnt++;
            if (done) begin
                done_cnt++;
                if (exp_done_q.size() == 0) chk("done_unexpected", 1, 0);
                else chk("done_cycle", cyc, exp_done_q.pop_front());
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0, e0, d0;
        cfg_bus.cfg_valid = 1'b0;
        cfg_bus.cfg_idiv  = '0;
        cfg_bus.cfg_fdiv  = '0;
        cfg_bus.cfg_odiv0 = '0;
        cfg_bus.cfg_duty0 = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_pll_rst", pll_rst, 1);
        chk_dyn("rst", 2, 32, 100, 100);
        chk("rst_clk_ok", clk_ok, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_cfg_ready", cfg_bus.cfg_ready, 0);
        chk("rst_loss", lock_loss_cnt, 0);
        rst = 1'b0;

        // Power-up: lock arrives 200 cycles after release (one timeout retry before that)
        repeat (200) @(negedge clk);
        raise_lock_expect_done();
        wait_clk_ok("pwr_clk_ok");
        chk("pwr_rst_pulses", rst_pulses, 2);
        chk("pwr_done_cnt", done_cnt, 1);
        chk("pwr_cfg_ready", cfg_bus.cfg_ready, 1);
        chk_dyn("pwr", 2, 32, 100, 100);

        // Reconfigure odiv0/duty0 to 200
        send_cfg(10'd2, 10'd32, 10'd200, 10'd200, 1'b1);
        chk("recfg_cfg_ready", cfg_bus.cfg_ready, 0);
        chk("recfg_pll_rst", pll_rst, 1);
        chk_dyn("recfg", 2, 32, 200, 200);
        wait_pll_rst_low("recfg_rst_end");

        // Glitch in STABLE restarts qualification without done
        d0 = done_cnt;
        pll_lock = 1'b1;
        repeat (20) @(negedge clk);
        chk("glitch_clk_ok", clk_ok, 0);
        pll_lock = 1'b0;
        repeat (5) @(negedge clk);
        chk("glitch_no_done", done_cnt, d0);
        raise_lock_expect_done();
        wait_clk_ok("glitch_relock");
        chk("glitch_done_cnt", done_cnt, d0 + 1);
        chk_dyn("glitch", 2, 32, 200, 200);

        // Lock loss in RUN
        p0 = rst_pulses;
        pll_lock = 1'b0;
        for (int i = 0; i < 3 && clk_ok; i++) @(negedge clk);
        chk("loss_clk_ok_low", clk_ok, 0);
        chk("loss_cnt", lock_loss_cnt, 1);
        repeat (7) @(negedge clk);
        raise_lock_expect_done();
        wait_clk_ok("loss_relock");
        chk("loss_no_pll_rst", rst_pulses, p0);

        // Rejected request (fdiv = 0) in RUN
        e0 = err_cnt;
        send_cfg(10'd2, 10'd0, 10'd50, 10'd50, 1'b0);
        chk("rej_err", err, 1);
        chk_dyn("rej", 2, 32, 200, 200);
        chk("rej_clk_ok", clk_ok, 1);
        @(negedge clk);
        chk("rej_err_pulse", err, 0);
        chk("rej_err_cnt", err_cnt, e0 + 1);

        // 300 more lock drops: counter saturates at 255
        for (int n = 0; n < 300; n++) begin
            pll_lock = 1'b0;
            repeat (4) @(negedge clk);
            raise_lock_expect_done();
            for (int i = 0; i < 200 && !clk_ok; i++) @(negedge clk);
        end
        chk("sat_clk_ok", clk_ok, 1);
        chk("sat_loss", lock_loss_cnt, 255);

        // Timeout and retry into FAIL
        p0 = rst_pulses;
        e0 = err_cnt;
        send_cfg(10'd2, 10'd32, 10'd100, 10'd100, 1'b1);
        for (int i = 0; i < 600 && !cfg_bus.cfg_ready; i++) @(negedge clk);
        chk("fail_cfg_ready", cfg_bus.cfg_ready, 1);
        chk("fail_pulses", rst_pulses - p0, RETRY_MAX);
        chk("fail_err_cnt", err_cnt - e0, 1);
        chk("fail_clk_ok", clk_ok, 0);
        chk("fail_pll_rst", pll_rst, 0);
        repeat (5) @(negedge clk);
        chk("fail_hold", cfg_bus.cfg_ready, 1);
        chk("fail_single_err", err_cnt - e0, 1);

        // Rejected request in FAIL keeps FAIL
        send_cfg(10'd0, 10'd32, 10'd100, 10'd100, 1'b0);
        chk("failrej_err", err, 1);
        chk("failrej_cfg_ready", cfg_bus.cfg_ready, 1);
        chk_dyn("failrej", 2, 32, 100, 100);

        // Mid-sequence reset during WAIT_LOCK after reconfiguration
        send_cfg(10'd4, 10'd40, 10'd200, 10'd200, 1'b0);
        wait_pll_rst_low("mid_rst_end");
        repeat (5) @(negedge clk);
        chk_dyn("mid_pre", 4, 40, 200, 200);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_pll_rst", pll_rst, 1);
        chk_dyn("mid_post", 2, 32, 100, 100);
        chk("mid_loss", lock_loss_cnt, 0);
        chk("mid_cfg_ready", cfg_bus.cfg_ready, 0);
        wait_pll_rst_low("mid_rst_done");
        raise_lock_expect_done();
        wait_clk_ok("mid_relock");

        repeat (3) @(negedge clk);
        chk("done_queue_empty", exp_done_q.size(), 0);
        chk("done_total", done_cnt, pushes);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pll_reconfig_ctrl.md
# pll_reconfig_ctrl

Controller that drives the PLL dynamic-configuration and reset inputs and supervises `pll_lock`. It is the initiator side of the PLL control interface: it applies power-up and requested divider/duty settings, sequences `pll_rst`, waits for a qualified lock with timeout and retry, and reports clock health to the audio/FFT datapath. It sits between the system control logic and the PLL instance in the clocking top.

## Interface
Parameters:
- `RST_CYCLES`, 16: cycles `pll_rst` is held high per reset attempt (≥1).
- `LOCK_TIMEOUT`, 50000: cycles allowed in WAIT_LOCK before the attempt fails (≥2).
- `LOCK_STABLE`, 64: consecutive synchronized-lock cycles required before lock is declared (≥1).
- `RETRY_MAX`, 3: reset attempts per configuration before FAIL (≥1).

Ports:
- `clk` in 1: single system clock. All logic is on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `cfg_valid` in 1: new configuration request.
- `cfg_ready` out 1: request accepted on a cycle where `cfg_valid && cfg_ready`.
- `cfg_idiv`, `cfg_fdiv`, `cfg_odiv0`, `cfg_duty0` in 10 each: requested settings.
- `pll_lock` in 1: PLL lock, asynchronous to `clk`.
- `pll_rst` out 1: PLL reset, active high.
- `dyn_idiv`, `dyn_fdiv`, `dyn_odiv0`, `dyn_duty0` out 10 each: registered settings to the PLL.
- `clk_ok` out 1: qualified lock, high only in RUN.
- `done` out 1: one-cycle pulse on entry to RUN.
- `err` out 1: one-cycle pulse on entry to FAIL or on a rejected request.
- `lock_loss_cnt` out 8: saturating count of lock drops seen in RUN.

## Operation
- `pll_lock` passes through a 2-flop synchronizer to `lock_s`. All decisions use `lock_s`.
- States: PLL_RST, WAIT_LOCK, STABLE, RUN, FAIL.
- Reset values:
  - state = PLL_RST, `pll_rst` = 1.
  - `dyn_idiv` = 2, `dyn_fdiv` = 32, `dyn_odiv0` = 100, `dyn_duty0` = 100.
  - `clk_ok`, `done`, `err`, `cfg_ready` = 0; `lock_loss_cnt` = 0; retry count = 0.
- PLL_RST: `pll_rst` = 1 for exactly RST_CYCLES cycles, then go to WAIT_LOCK with `pll_rst` = 0 and the timer cleared.
- WAIT_LOCK:
  - `lock_s` = 1 → STABLE, stable counter cleared.
  - Timer reaches LOCK_TIMEOUT with no lock → increment retry count.
    - If retry count < RETRY_MAX → PLL_RST.
    - Otherwise → FAIL.
- STABLE:
  - `lock_s` = 0 → WAIT_LOCK; the timer is not cleared, so the timeout still bounds the attempt.
  - LOCK_STABLE consecutive high cycles → RUN, `done` pulse, retry count cleared.
- RUN:
  - `clk_ok` = 1, `cfg_ready` = 1.
  - `lock_s` falling → `lock_loss_cnt` + 1 (saturates at 255), `clk_ok` = 0 on the next cycle, go to WAIT_LOCK with timer cleared. No PLL reset is issued.
- FAIL:
  - `pll_rst` = 0, `clk_ok` = 0, `cfg_ready` = 1.
  - The state is left only by a new request or by `rst`.
- Request acceptance (RUN or FAIL only):
  - If any of `cfg_idiv`, `cfg_fdiv`, `cfg_odiv0`, `cfg_duty0` is 0: the request is consumed, `err` pulses, and state and `dyn_*` are unchanged.
  - Otherwise `dyn_*` load the request on the accepting edge, retry count is cleared, and state becomes PLL_RST.
- `cfg_ready` = 0 in PLL_RST, WAIT_LOCK and STABLE. Requests wait there; they are never dropped.
- `rst` asserted in any state, including mid-sequence, restores all reset values on the next edge and restarts the power-up sequence with the default settings.

## Timing
- `cfg_ready` is decoded from the registered state. Accept edge → `pll_rst` = 1 and the new `dyn_*` values are visible on the following cycle.
- `dyn_*` change only on an accept edge or on reset. They are stable throughout PLL_RST, WAIT_LOCK and STABLE.
- `pll_lock` rise → `lock_s` rise 2 cycles later → `done` and `clk_ok` rise LOCK_STABLE cycles after that.
- `pll_lock` fall in RUN → `clk_ok` falls no more than 3 cycles later.
- Worst-case time to FAIL = RETRY_MAX × (RST_CYCLES + LOCK_TIMEOUT) cycles plus FSM overhead.
- `done` and `err` never assert in the same cycle.

## Test plan
- Power-up:
  - Stimulus: `rst` released; `pll_lock` rises 200 cycles later (RST_CYCLES=16, LOCK_STABLE=64).
  - Required: `pll_rst` high for exactly 16 cycles; `dyn_*` = 2/32/100/100; one `done` pulse 66 cycles after the `pll_lock` rise; `clk_ok` = 1.
- Reconfigure:
  - Stimulus: in RUN, request odiv0=200, duty0=200.
  - Required: `cfg_ready` drops; `dyn_odiv0` = `dyn_duty0` = 200; `pll_rst` pulses 16 cycles; `done` after re-lock.
- Timeout and retry:
  - Stimulus: `pll_lock` held 0 with LOCK_TIMEOUT=100, RETRY_MAX=3.
  - Required: 3 `pll_rst` pulses; then FAIL with one `err` pulse, `clk_ok` = 0, `cfg_ready` = 1.
- Glitch in STABLE and lock loss in RUN:
  - Stimulus: `pll_lock` drops for 5 cycles during STABLE; then, after RUN, drops for 10 cycles.
  - Required: the STABLE glitch restarts qualification with no `done`. The RUN drop gives `lock_loss_cnt` = 1, `clk_ok` low within 3 cycles, no `pll_rst`, and re-qualification followed by `done`.
- Rejection and saturation:
  - Stimulus: request with `cfg_fdiv` = 0; then 300 lock drops in RUN.
  - Required: the rejected request gives an `err` pulse with `dyn_*` unchanged; `lock_loss_cnt` saturates at 255.
- Mid-sequence reset:
  - Stimulus: assert `rst` for 1 cycle during WAIT_LOCK after a reconfiguration.
  - Required: `dyn_*` return to 2/32/100/100; `pll_rst` = 1 on the next cycle; `lock_loss_cnt` = 0.
